cache_line_ctrl: RTL and testbench

- Parametrised successor to the single-word cache read FSM.
- Sits between the CPU-side cache arrays (tag compare supplies hit/miss/dirty) and the main-memory port.
- Handles multi-word line fills, and write-back of dirty victims (or write-through when configured).
- Drives pc_stall, cache update strobes and saturating hit/miss statistics counters.

---
 rtl/cache_line_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cache_line_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cache_line_ctrl.sv
// Cache line controller: multi-word line fill, dirty-victim write-back or write-through
// stores, CPU stall generation and saturating hit/miss statistics.
module cache_line_ctrl #(
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter bit          WRITE_BACK     = 1'b1,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned IDX_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req,
    input  logic                 we,
    input  logic                 hit,
    input  logic                 miss,
    input  logic                 dirty,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [IDX_W-1:0]     mem_word_idx,
    output logic                 update,
    output logic                 set_dirty,
    output logic                 clr_dirty,
    output logic                 pc_stall,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [2:0] {
        ST_LOOKUP    = 3'd0,
        ST_WRITEBACK = 3'd1,
        ST_FILL      = 3'd2,
        ST_DONE      = 3'd3,
        ST_WT        = 3'd4
    } state_e;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 store_q, store_d;
    logic [CNT_WIDTH-1:0] hit_q, hit_d;
    logic [CNT_WIDTH-1:0] miss_q, miss_d;
    logic                 hit_inc, miss_inc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_LOOKUP;
            cnt_q   <= '0;
            store_q <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    // Next-state and combinational outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        store_d      = store_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_word_idx = '0;
        update       = 1'b0;
        set_dirty    = 1'b0;
        clr_dirty    = 1'b0;
        pc_stall     = 1'b0;

        case (state_q)
            ST_LOOKUP: begin
                if (req && hit) begin
                    hit_inc = 1'b1;
                    if (we) begin
                        if (WRITE_BACK) begin
                            set_dirty = 1'b1;
                        end else begin
                            pc_stall = 1'b1;
                            state_d  = ST_WT;
                        end
                    end
                end else if (req && miss) begin
                    pc_stall = 1'b1;
                    miss_inc = 1'b1;
                    store_d  = we;
                    state_d  = (WRITE_BACK && dirty) ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                pc_stall     = 1'b1;
                mem_word_idx = cnt_q;
                if (mem_ack) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_FILL;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_FILL: begin
                mem_req      = 1'b1;
                pc_stall     = 1'b1;
                mem_word_idx = cnt_q;
                if (mem_ack) begin
                    update = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d     = '0;
                        clr_dirty = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                pc_stall = 1'b1;
                state_d  = ST_LOOKUP;
                if (store_q) begin
                    if (WRITE_BACK) begin
                        set_dirty = 1'b1;
                    end else begin
                        state_d = ST_WT;
                    end
                end
            end
            ST_WT: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                pc_stall = 1'b1;
                if (mem_ack) begin
                    store_d = 1'b0;
                    state_d = ST_LOOKUP;
                end
            end
            default: begin
                state_d = ST_LOOKUP;
                cnt_d   = '0;
                store_d = 1'b0;
            end
        endcase
    end

    // Saturating statistics
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (hit_inc && (hit_q != CNT_MAX)) begin
            hit_d = hit_q + CNT_WIDTH'(1);
        end
        if (miss_inc && (miss_q != CNT_MAX)) begin
            miss_d = miss_q + CNT_WIDTH'(1);
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Bench for cache_line_ctrl: a write-back instance (4-word lines, 4-bit counters) and a
// write-through instance (4-word lines, 16-bit counters), vector table plus corner sequences.
module tb_cache_line_ctrl;

    typedef struct packed {
        logic rst, req, we, hit, miss, dirty, ack;
    } vin_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] idx;
        logic       update;
        logic       set_dirty;
        logic       clr_dirty;
        logic       pc_stall;
    } vout_t;

    typedef struct packed {
        vin_t  vi;
        vout_t vo;
    } vec_t;

    logic  CLK;
    vin_t  in_a, in_b;
    vout_t out_a, out_b;

    logic        a_mem_req, a_mem_we, a_update, a_set_dirty, a_clr_dirty, a_pc_stall;
    logic [1:0]  a_idx;
    logic [3:0]  a_hit_count, a_miss_count;
    logic        b_mem_req, b_mem_we, b_update, b_set_dirty, b_clr_dirty, b_pc_stall;
    logic [1:0]  b_idx;
    logic [15:0] b_hit_count, b_miss_count;

    vout_t exp_q[$];
    vec_t  tbl[$];
    int    errors = 0;
    int    checks = 0;
    int    stall_acc = 0;

    cache_line_ctrl #(.WORDS_PER_LINE(4), .WRITE_BACK(1'b1), .CNT_WIDTH(4)) u_wb (
        .CLK(CLK), .RST(in_a.rst), .req(in_a.req), .we(in_a.we), .hit(in_a.hit),
        .miss(in_a.miss), .dirty(in_a.dirty), .mem_ack(in_a.ack),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_word_idx(a_idx), .update(a_update),
        .set_dirty(a_set_dirty), .clr_dirty(a_clr_dirty), .pc_stall(a_pc_stall),
        .hit_count(a_hit_count), .miss_count(a_miss_count)
    );

    cache_line_ctrl #(.WORDS_PER_LINE(4), .WRITE_BACK(1'b0), .CNT_WIDTH(16)) u_wt (
        .CLK(CLK), .RST(in_b.rst), .req(in_b.req), .we(in_b.we), .hit(in_b.hit),
        .miss(in_b.miss), .dirty(in_b.dirty), .mem_ack(in_b.ack),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_word_idx(b_idx), .update(b_update),
        .set_dirty(b_set_dirty), .clr_dirty(b_clr_dirty), .pc_stall(b_pc_stall),
        .hit_count(b_hit_count), .miss_count(b_miss_count)
    );

    assign out_a = {a_mem_req, a_mem_we, a_idx, a_update, a_set_dirty, a_clr_dirty, a_pc_stall};
    assign out_b = {b_mem_req, b_mem_we, b_idx, b_update, b_set_dirty, b_clr_dirty, b_pc_stall};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vin_t mk_in(input logic rst, req, we, hit, miss, dirty, ack);
        return '{rst, req, we, hit, miss, dirty, ack};
    endfunction

    function automatic vout_t mk_out(input logic mr, mw, input logic [1:0] idx,
                                     input logic upd, sd, cd, st);
        return '{mr, mw, idx, upd, sd, cd, st};
    endfunction

    task automatic chk_val(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle, queue the expectation, compare mid-cycle, then idle the DUT
    task automatic step(input bit sel, input vin_t vi, input vout_t ve, input string nm);
        vout_t got;
        vout_t want;
        if (sel) in_b = vi; else in_a = vi;
        exp_q.push_back(ve);
        @(negedge CLK);
        got  = sel ? out_b : out_a;
        want = exp_q.pop_front();
        if (got.pc_stall) stall_acc++;
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b (mreq,mwe,idx,upd,sd,cd,stall)", nm, got, want);
        end
        @(posedge CLK);
        #1;
        if (sel) in_b = '0; else in_a = '0;
    endtask

    initial begin
        vin_t  idle;
        vout_t zero;
        idle = '0;
        zero = '0;

        // Read hits, then a clean read miss with zero-wait memory
        for (int i = 0; i < 5; i++) tbl.push_back('{mk_in(0,1,0,1,0,0,0), zero});
        tbl.push_back('{mk_in(0,1,0,0,1,0,0), mk_out(0,0,2'd0,0,0,0,1)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,1), mk_out(1,0,2'd0,1,0,0,1)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,1), mk_out(1,0,2'd1,1,0,0,1)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,1), mk_out(1,0,2'd2,1,0,0,1)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,1), mk_out(1,0,2'd3,1,0,1,1)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0), mk_out(0,0,2'd0,0,0,0,1)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,1), zero});

        in_a = '0; in_b = '0;
        in_a.rst = 1'b1; in_b.rst = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        in_a = '0; in_b = '0;

        step(0, idle, zero, "reset_outputs_a");
        step(1, idle, zero, "reset_outputs_b");
        chk_val("reset_hit_a", int'(a_hit_count), 0);
        chk_val("reset_miss_a", int'(a_miss_count), 0);
        chk_val("reset_hit_b", int'(b_hit_count), 0);

        stall_acc = 0;
        for (int i = 0; i < tbl.size(); i++)
            step(0, tbl[i].vi, tbl[i].vo, $sformatf("vec_a%0d", i));
        chk_val("clean_miss_stall", stall_acc, 6);
        chk_val("hit_count_5", int'(a_hit_count), 5);
        chk_val("miss_count_1", int'(a_miss_count), 1);

        step(0, mk_in(0,1,0,1,1,0,0), zero, "hit_and_miss");
        step(0, mk_in(0,1,1,1,0,0,0), mk_out(0,0,2'd0,0,1,0,0), "wb_store_hit");
        chk_val("hit_count_7", int'(a_hit_count), 7);

        // Dirty store miss, memory acks every other cycle
        stall_acc = 0;
        step(0, mk_in(0,1,1,0,1,1,0), mk_out(0,0,2'd0,0,0,0,1), "dirty_miss_lookup");
        for (int w = 0; w < 4; w++) begin
            step(0, idle, mk_out(1,1,2'(w),0,0,0,1), $sformatf("wb_wait%0d", w));
            step(0, mk_in(0,0,0,0,0,0,1), mk_out(1,1,2'(w),0,0,0,1), $sformatf("wb_ack%0d", w));
        end
        for (int w = 0; w < 4; w++) begin
            step(0, idle, mk_out(1,0,2'(w),0,0,0,1), $sformatf("fill_wait%0d", w));
            step(0, mk_in(0,0,0,0,0,0,1), mk_out(1,0,2'(w),1,0,(w == 3),1),
                 $sformatf("fill_ack%0d", w));
        end
        step(0, idle, mk_out(0,0,2'd0,0,1,0,1), "done_set_dirty");
        step(0, idle, zero, "after_dirty_miss");
        chk_val("dirty_miss_stall", stall_acc, 18);
        chk_val("miss_count_2", int'(a_miss_count), 2);

        // Reset in the middle of a fill
        step(0, mk_in(0,1,0,0,1,0,0), mk_out(0,0,2'd0,0,0,0,1), "rst_seq_miss");
        step(0, mk_in(0,0,0,0,0,0,1), mk_out(1,0,2'd0,1,0,0,1), "rst_seq_ack0");
        step(0, mk_in(0,0,0,0,0,0,1), mk_out(1,0,2'd1,1,0,0,1), "rst_seq_ack1");
        step(0, mk_in(1,0,0,0,0,0,0), mk_out(1,0,2'd2,0,0,0,1), "rst_cycle");
        chk_val("rst_hit_cleared", int'(a_hit_count), 0);
        chk_val("rst_miss_cleared", int'(a_miss_count), 0);
        step(0, mk_in(0,0,0,0,0,0,1), zero, "after_rst_idle");
        step(0, mk_in(0,1,0,0,1,0,0), mk_out(0,0,2'd0,0,0,0,1), "restart_miss");
        for (int w = 0; w < 4; w++)
            step(0, mk_in(0,0,0,0,0,0,1), mk_out(1,0,2'(w),1,0,(w == 3),1),
                 $sformatf("restart_fill%0d", w));
        step(0, idle, mk_out(0,0,2'd0,0,0,0,1), "restart_done");

        // Hit counter saturation at 4 bits
        for (int i = 0; i < 20; i++) step(0, mk_in(0,1,0,1,0,0,0), zero, "sat_hit");
        chk_val("hit_saturated", int'(a_hit_count), 15);
        chk_val("miss_after_sat", int'(a_miss_count), 1);

        // Write-through store hit
        step(1, mk_in(0,1,1,1,0,0,0), mk_out(0,0,2'd0,0,0,0,1), "wt_store_hit");
        step(1, idle, mk_out(1,1,2'd0,0,0,0,1), "wt_wait");
        step(1, mk_in(0,0,0,0,0,0,1), mk_out(1,1,2'd0,0,0,0,1), "wt_ack");
        step(1, idle, zero, "wt_release");
        step(1, mk_in(0,1,0,1,0,1,0), zero, "wt_read_hit");
        chk_val("wt_hit_count", int'(b_hit_count), 2);

        // Write-through store miss: dirty ignored, fill then one write-through word
        step(1, mk_in(0,1,1,0,1,1,0), mk_out(0,0,2'd0,0,0,0,1), "wt_miss_lookup");
        for (int w = 0; w < 4; w++)
            step(1, mk_in(0,0,0,0,0,0,1), mk_out(1,0,2'(w),1,0,(w == 3),1),
                 $sformatf("wt_fill%0d", w));
        step(1, idle, mk_out(0,0,2'd0,0,0,0,1), "wt_done");
        step(1, mk_in(0,0,0,0,0,0,1), mk_out(1,1,2'd0,0,0,0,1), "wt_miss_store");
        step(1, idle, zero, "wt_miss_release");
        chk_val("wt_miss_count", int'(b_miss_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
